// File: rtl/sound_synth_if.sv
// rtl/sound_synth_if.sv - trigger/parameter bus and mixed DAC output of the tone synthesiser
interface sound_synth_if #(
  parameter int N     = 7,
  parameter int CH    = 2,
  parameter int DIV_W = 12,
  parameter int DUR_W = 16
);
  logic [CH-1:0]       trig_i;
  logic [CH*DIV_W-1:0] period_i;
  logic [CH*DUR_W-1:0] dur_i;
  logic [CH-1:0]       mode_i;
  logic [CH-1:0]       busy_o;
  logic [N-1:0]        dacCount;

  // event logic side: issues triggers, observes busy and the DAC count
  modport master (
    output trig_i, period_i, dur_i, mode_i,
    input  busy_o, dacCount
  );

  // synthesiser side
  modport slave (
    input  trig_i, period_i, dur_i, mode_i,
    output busy_o, dacCount
  );
endinterface

// File: rtl/sound_synth.sv
// rtl/sound_synth.sv - CH-channel square/sawtooth tone synthesiser mixed onto one N-bit DAC count (SOUND_SAW_EN enables sawtooth)
module sound_synth #(
  parameter int N     = 7,
  parameter int CH    = 2,
  parameter int DIV_W = 12,
  parameter int DUR_W = 16
) (
  input logic         clk,
  input logic         rst,
  sound_synth_if.slave bus
);
  localparam int L = $clog2(CH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  logic [N-1:0]   w_sample [CH];
  logic           w_busy   [CH];
  logic [N+L-1:0] w_sum;
  logic [N-1:0]   r_dac;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_per;
    logic [DUR_W-1:0] r_dur;
    logic             r_level;
    logic [DIV_W-1:0] w_period;
    logic [DUR_W-1:0] w_dur;
    logic             w_wrap;

    assign w_period = bus.period_i[c*DIV_W +: DIV_W];
    assign w_dur    = bus.dur_i[c*DUR_W +: DUR_W];
    // r_per is never 0 while playing, so per-1 cannot underflow
    assign w_wrap   = (r_phase == r_per - 1'b1);

    // play FSM: a trigger always wins over the natural countdown and expiry
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_phase <= '0;
        r_per   <= '0;
        r_dur   <= '0;
        r_level <= 1'b0;
      end else if (bus.trig_i[c]) begin
        if (w_dur != '0) begin
          r_state <= S_PLAY;
          r_phase <= '0;
          r_per   <= (w_period == '0) ? DIV_W'(1) : w_period;
          r_dur   <= w_dur;
          r_level <= 1'b1;
        end else begin
          r_state <= S_IDLE;
          r_level <= 1'b0;
        end
      end else if (r_state == S_PLAY) begin
        r_phase <= w_wrap ? '0 : r_phase + 1'b1;
        if (w_wrap) r_level <= ~r_level;
        r_dur <= r_dur - 1'b1;
        if (r_dur == DUR_W'(1)) r_state <= S_IDLE;
      end
    end

`ifdef SOUND_SAW_EN
    logic         r_mode;
    logic [N-1:0] r_saw;

    // sawtooth step counter and latched waveform mode
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mode <= 1'b0;
        r_saw  <= '0;
      end else if (bus.trig_i[c]) begin
        if (w_dur != '0) r_mode <= bus.mode_i[c];
        r_saw <= '0;
      end else if (r_state == S_PLAY && w_wrap) begin
        r_saw <= r_saw + 1'b1;
      end
    end

    assign w_sample[c] = (r_state == S_IDLE) ? '0 :
                         r_mode ? r_saw : {N{r_level}};
`else
    assign w_sample[c] = (r_state == S_IDLE) ? '0 : {N{r_level}};
`endif

    assign w_busy[c] = (r_state == S_PLAY);
  end

  // zero-extended sum of all channel samples; N+L bits holds CH full-scale samples
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < CH; c++) begin
      w_sum = w_sum + (N+L)'(w_sample[c]);
    end
  end

  // pack per-channel busy flags onto the bus
  always_comb begin
    bus.busy_o = '0;
    for (int c = 0; c < CH; c++) begin
      bus.busy_o[c] = w_busy[c];
    end
  end

  // scale the mix back to N bits and register it for the DAC
  always_ff @(posedge clk) begin
    if (rst) r_dac <= '0;
    else     r_dac <= w_sum[N+L-1:L];
  end

  assign bus.dacCount = r_dac;
endmodule

// File: tb/tb_sound_synth.sv
// tb/tb_sound_synth.sv - directed self-checking bench for sound_synth (N=7, CH=2)
module tb_sound_synth;
  localparam int N     = 7;
  localparam int CH    = 2;
  localparam int DIV_W = 12;
  localparam int DUR_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_v;

  sound_synth_if #(.N(N), .CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W)) u_if ();

  sound_synth #(.N(N), .CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input int per, input int dur, input int mode);
    u_if.period_i[c*DIV_W +: DIV_W] = DIV_W'(per);
    u_if.dur_i[c*DUR_W +: DUR_W]    = DUR_W'(dur);
    u_if.mode_i[c]                  = mode[0];
  endtask

  // hold trig for one edge; returns in cycle T+1
  task automatic fire(input logic [CH-1:0] t);
    u_if.trig_i = t;
    step();
    u_if.trig_i = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if.trig_i   = '0;
    u_if.period_i = '0;
    u_if.dur_i    = '0;
    u_if.mode_i   = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy", int'(u_if.busy_o), 0);
    check("reset_dac", int'(u_if.dacCount), 0);

    // single square channel, period 4, dur 16
    set_ch(0, 4, 16, 0);
    fire(2'b01);
    check("sq_busy_k1", int'(u_if.busy_o), 1);
    for (int k = 2; k <= 19; k++) begin
      step();
      exp_v = (k <= 17 && ((k - 2) / 4) % 2 == 0) ? 63 : 0;
      check($sformatf("sq_dac_k%0d", k), int'(u_if.dacCount), exp_v);
      check($sformatf("sq_busy_k%0d", k), int'(u_if.busy_o), (k <= 16) ? 1 : 0);
    end

    // reset held two cycles in the middle of play
    set_ch(0, 4, 100, 0);
    fire(2'b01);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("midrst_busy", int'(u_if.busy_o), 0);
    check("midrst_dac", int'(u_if.dacCount), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_quiet_busy", int'(u_if.busy_o), 0);
      check("midrst_quiet_dac", int'(u_if.dacCount), 0);
    end

    // both channels together, period 3, dur 12
    set_ch(0, 3, 12, 0);
    set_ch(1, 3, 12, 0);
    fire(2'b11);
    check("dual_busy_k1", int'(u_if.busy_o), 3);
    for (int k = 2; k <= 14; k++) begin
      step();
      exp_v = (k <= 13 && ((k - 2) / 3) % 2 == 0) ? 127 : 0;
      check($sformatf("dual_dac_k%0d", k), int'(u_if.dacCount), exp_v);
      check($sformatf("dual_busy_k%0d", k), int'(u_if.busy_o), (k <= 12) ? 3 : 0);
    end

    // retrigger at play cycle 10 with period 2, dur 5
    set_ch(0, 4, 16, 0);
    fire(2'b01);
    for (int k = 2; k <= 10; k++) step();
    set_ch(0, 2, 5, 0);
    fire(2'b01);
    check("retrig_busy_r1", int'(u_if.busy_o), 1);
    for (int j = 2; j <= 6; j++) begin
      step();
      exp_v = (j == 4 || j == 5) ? 0 : 63;
      check($sformatf("retrig_dac_r%0d", j), int'(u_if.dacCount), exp_v);
      check($sformatf("retrig_busy_r%0d", j), int'(u_if.busy_o), (j <= 5) ? 1 : 0);
    end

    // trigger coincident with natural expiry keeps the channel playing
    set_ch(0, 2, 3, 0);
    fire(2'b01);
    step();
    step();
    check("expiry_busy_k3", int'(u_if.busy_o), 1);
    set_ch(0, 2, 4, 0);
    fire(2'b01);
    check("expiry_busy_k4", int'(u_if.busy_o), 1);
    step();
    step();
    step();
    check("expiry_busy_k7", int'(u_if.busy_o), 1);
    step();
    check("expiry_busy_k8", int'(u_if.busy_o), 0);

    // stop command on ch1 during play
    set_ch(1, 3, 20, 0);
    fire(2'b10);
    check("stop_busy_k1", int'(u_if.busy_o), 2);
    step();
    check("stop_dac_k2", int'(u_if.dacCount), 63);
    set_ch(1, 3, 0, 0);
    fire(2'b10);
    check("stop_busy_k3", int'(u_if.busy_o), 0);
    check("stop_dac_k3", int'(u_if.dacCount), 63);
    step();
    check("stop_dac_k4", int'(u_if.dacCount), 0);

    // period 0 and period 1 give the same every-cycle toggle
    for (int p = 0; p <= 1; p++) begin
      set_ch(0, p, 6, 0);
      fire(2'b01);
      for (int k = 2; k <= 8; k++) begin
        step();
        exp_v = (k <= 7 && k % 2 == 0) ? 63 : 0;
        check($sformatf("per%0d_dac_k%0d", p, k), int'(u_if.dacCount), exp_v);
      end
    end

    // sawtooth request: period 1, dur 300
    set_ch(0, 1, 300, 1);
    fire(2'b01);
    for (int k = 2; k <= 135; k++) begin
      step();
`ifdef SOUND_SAW_EN
      exp_v = ((k - 2) % 128) / 2;
`else
      exp_v = (k % 2 == 0) ? 63 : 0;
`endif
      check($sformatf("saw_dac_k%0d", k), int'(u_if.dacCount), exp_v);
    end
    set_ch(0, 1, 0, 0);
    fire(2'b01);
    check("saw_stop_busy", int'(u_if.busy_o), 0);
    step();
    check("saw_stop_dac", int'(u_if.dacCount), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_synth.md
Name: sound_synth

Overview:
- Parametrised multi-channel tone synthesiser; successor to the single-voice collision/button sound path.
- CH independent channels, each triggered with a period, duration and waveform mode, each with its own play FSM.
- Channel samples are summed, scaled and registered onto one N-bit DAC count for the audio DAC / PWM stage.
- Upstream event logic (collision, button, direction) issues triggers; this block owns all timing.

Parameters:
- N, 7, DAC output width in bits; also the per-channel sample width.
- CH, 2, number of channels; must be a power of two, 1..8. L = log2(CH).
- DIV_W, 12, width of the period field and phase counter per channel.
- DUR_W, 16, width of the duration field and duration counter per channel.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- trig_i  in  CH  per-channel trigger pulse; bit c starts, restarts or stops channel c
- period_i  in  CH*DIV_W  per-channel period in clk cycles; channel c at [c*DIV_W +: DIV_W]
- dur_i  in  CH*DUR_W  per-channel duration in clk cycles; channel c at [c*DUR_W +: DUR_W]
- mode_i  in  CH  per-channel waveform: 0 = square, 1 = sawtooth
- busy_o  out  CH  channel c is in PLAY
- dacCount  out  N  mixed, registered DAC count

Behaviour:
Reset:
- rst is sampled only on a rising clk edge; it overrides trig_i.
- All channels go to IDLE; phase, duration, level and saw registers clear.
- busy_o = 0 and dacCount = 0 on the cycle after rst is sampled.

Per-channel FSM, states IDLE and PLAY:
- Trigger sampling: period_i, dur_i and mode_i are sampled only in a cycle where trig_i[c] = 1, and held until the next trigger.
- trig_i[c] with dur_i != 0, from IDLE or PLAY: next state PLAY.
  - Loads phase = 0, dur_cnt = dur, per_eff = max(period, 1), level = 1, saw = 0, and latches mode.
  - A retrigger during PLAY fully restarts the channel.
- trig_i[c] with dur_i = 0: stop command. Next state IDLE from any state; clears level and saw.
- In PLAY, with no trigger, every cycle:
  - phase increments. When phase = per_eff - 1, phase wraps to 0 and a wrap event occurs.
  - On a wrap event, square mode toggles level; sawtooth mode increments saw (N bits, 2^N-1 wraps to 0).
  - dur_cnt decrements. If dur_cnt = 1, next state is IDLE.
- busy_o[c] = 1 exactly while in PLAY. A trigger at cycle T with duration D gives busy_o[c] high for cycles T+1 .. T+D.

Channel sample (N bits):
- IDLE: 0.
- Square: level ? 2^N-1 : 0.
- Sawtooth: saw.

Mixer:
- sum = zero-extended sum of all CH samples, N+L bits; it cannot overflow.
- dacCount <= sum[N+L-1:L], registered.
- dacCount in cycle k+1 reflects channel state in cycle k. A trigger at T therefore produces its first output effect at T+2.

Boundaries:
- Period 0 behaves as period 1: wrap every cycle.
- Maximum period (2^DIV_W - 1) and maximum duration are handled without counter overflow.
- Simultaneous triggers on several channels are independent; there is no cross-channel priority.
- A trigger in the same cycle as a channel's natural expiry: the trigger wins and the channel stays in PLAY.

Optional Feature:
- Macro: SOUND_SAW_EN.
- Defined: mode_i = 1 selects sawtooth as described above.
- Not defined: mode_i is ignored, all channels are square, and no saw registers are synthesised. busy_o and dacCount behaviour is otherwise identical.

Test Plan:
1. Reset: hold rst 2 cycles mid-play -> busy_o = 00, dacCount = 0 the following cycle; no output until the next trigger.
2. N=7, CH=2: trig ch0, period 4, dur 16, square at T -> busy_o[0] high T+1..T+16. dacCount = 63 for T+2..T+5, 0 for T+6..T+9, and so on; 0 from T+18 onward.
3. Trig ch0 and ch1 in the same cycle, both period 3, dur 12, square -> dacCount alternates 127 / 0 in 3-cycle runs; both busy bits drop together after 12 cycles.
4. Retrigger ch0 at play cycle 10 with dur 5, period 2 -> phase restarts with the level high; busy_o[0] falls exactly 5 cycles after the retrigger. Also: trigger coincident with expiry -> busy_o[0] stays high.
5. Stop: trig ch1 with dur 0 during PLAY -> busy_o[1] = 0 next cycle; ch1 contributes 0 from the following dacCount. Also: period 0 trigger gives the same output as period 1.
6. With SOUND_SAW_EN: ch0 mode 1, period 1, dur 300 -> dacCount = saw >> 1: 0,0,1,1,... up to 63,63, then wraps to 0. Without the macro, the same stimulus gives square output.
